// File: rtl/regbank_wb_arbiter.sv
// Round-robin write-port arbiter for the 16 x 32-bit register bank.
// Picks one writeback source per cycle and drives the bank's registered write port.
module regbank_wb_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_dest,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 hold,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_dest,
  output logic [(1<<AW)-1:0]   wr_onehot,
  output logic [DW-1:0]        wr_data,
  output logic [15:0]          wr_count
);

  localparam int unsigned NREG = 1 << AW;
  localparam int unsigned PW   = $clog2(NREQ);
  localparam int unsigned CW   = 16;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_dest_q, wr_dest_d;
  logic [NREG-1:0] wr_onehot_q, wr_onehot_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [CW-1:0]   wr_count_q, wr_count_d;

  logic [NREQ-1:0] grant_c;
  logic            grant_any_c;
  logic [PW-1:0]   grant_idx_c;
  logic [PW:0]     slot_sum_c;
  logic [PW-1:0]   slot_idx_c;
  logic [AW-1:0]   sel_dest_c;
  logic [DW-1:0]   sel_data_c;

  // Search rr_ptr, rr_ptr+1, rr_ptr+2 (mod NREQ); first valid requester wins.
  always_comb begin
    grant_c     = '0;
    grant_any_c = 1'b0;
    slot_sum_c  = '0;
    slot_idx_c  = '0;
    if (rst_n && !hold) begin
      for (int i = 0; i < NREQ; i++) begin
        slot_sum_c = {1'b0, rr_ptr_q} + (PW+1)'(i);
        if (slot_sum_c >= (PW+1)'(NREQ)) begin
          slot_sum_c = slot_sum_c - (PW+1)'(NREQ);
        end
        slot_idx_c = PW'(slot_sum_c);
        for (int k = 0; k < NREQ; k++) begin
          if (!grant_any_c && slot_idx_c == PW'(k) && req_valid[k]) begin
            grant_c[k]  = 1'b1;
            grant_any_c = 1'b1;
          end
        end
      end
    end
  end

  // Payload mux driven by the one-hot grant.
  always_comb begin
    grant_idx_c = rr_ptr_q;
    sel_dest_c  = wr_dest_q;
    sel_data_c  = wr_data_q;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_c[k]) begin
        grant_idx_c = PW'(k);
        sel_dest_c  = req_dest[k*AW +: AW];
        sel_data_c  = req_data[k*DW +: DW];
      end
    end
  end

  assign req_ready = grant_c;

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    wr_en_d     = grant_any_c;
    wr_dest_d   = sel_dest_c;
    wr_data_d   = sel_data_c;
    wr_onehot_d = '0;
    wr_count_d  = wr_count_q;
    if (grant_any_c) begin
      rr_ptr_d    = (grant_idx_c == PW'(NREQ-1)) ? '0 : grant_idx_c + PW'(1);
      wr_onehot_d = NREG'(1) << sel_dest_c;
      wr_count_d  = wr_count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      wr_en_q     <= 1'b0;
      wr_dest_q   <= '0;
      wr_onehot_q <= '0;
      wr_data_q   <= '0;
      wr_count_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      wr_en_q     <= wr_en_d;
      wr_dest_q   <= wr_dest_d;
      wr_onehot_q <= wr_onehot_d;
      wr_data_q   <= wr_data_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_dest   = wr_dest_q;
  assign wr_onehot = wr_onehot_q;
  assign wr_data   = wr_data_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_regbank_wb_arbiter.sv
// Directed bench for regbank_wb_arbiter: reset, single request, contention,
// fairness, hold, same-destination ordering, counter wrap and mid-stream reset.
module tb_regbank_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic [2:0]  req_valid;
  logic [11:0] req_dest;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        hold;
  logic        wr_en;
  logic [3:0]  wr_dest;
  logic [15:0] wr_onehot;
  logic [31:0] wr_data;
  logic [15:0] wr_count;

  logic [3:0]  d [3];
  logic [31:0] dt [3];
  logic [15:0] exp_cnt;
  int          total;
  int          bad;

  assign req_dest = {d[2], d[1], d[0]};
  assign req_data = {dt[2], dt[1], dt[0]};

  regbank_wb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_dest  (req_dest),
    .req_data  (req_data),
    .req_ready (req_ready),
    .hold      (hold),
    .wr_en     (wr_en),
    .wr_dest   (wr_dest),
    .wr_onehot (wr_onehot),
    .wr_data   (wr_data),
    .wr_count  (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_wr(input string tag, input logic [3:0] dest,
                        input logic [15:0] oh, input logic [31:0] data);
    exp_cnt = exp_cnt + 16'd1;
    chk({tag, ".en"},     64'(wr_en),     64'(1'b1));
    chk({tag, ".dest"},   64'(wr_dest),   64'(dest));
    chk({tag, ".onehot"}, 64'(wr_onehot), 64'(oh));
    chk({tag, ".data"},   64'(wr_data),   64'(data));
    chk({tag, ".count"},  64'(wr_count),  64'(exp_cnt));
  endtask

  task automatic exp_idle(input string tag, input logic [3:0] dest, input logic [31:0] data);
    chk({tag, ".en"},     64'(wr_en),     64'(1'b0));
    chk({tag, ".dest"},   64'(wr_dest),   64'(dest));
    chk({tag, ".onehot"}, 64'(wr_onehot), 64'(16'h0000));
    chk({tag, ".data"},   64'(wr_data),   64'(data));
    chk({tag, ".count"},  64'(wr_count),  64'(exp_cnt));
  endtask

  task automatic exp_reset(input string tag);
    chk({tag, ".en"},     64'(wr_en),     64'(1'b0));
    chk({tag, ".dest"},   64'(wr_dest),   64'(4'd0));
    chk({tag, ".onehot"}, 64'(wr_onehot), 64'(16'h0000));
    chk({tag, ".data"},   64'(wr_data),   64'(32'h0));
    chk({tag, ".count"},  64'(wr_count),  64'(16'h0000));
    chk({tag, ".ready"},  64'(req_ready), 64'(3'b000));
  endtask

  initial begin
    int n;
    total = 0;
    bad = 0;
    exp_cnt = 16'h0000;
    rst_n = 1'b1;
    hold = 1'b0;
    req_valid = 3'b000;
    d[0] = 4'd1; d[1] = 4'd2; d[2] = 4'd3;
    dt[0] = 32'h1111_0000; dt[1] = 32'h2222_0001; dt[2] = 32'h3333_0002;

    // Reset asserted mid-cycle with every requester valid.
    #2;
    req_valid = 3'b111;
    rst_n = 1'b0;
    #1;
    exp_reset("rst");
    cyc();
    cyc();
    chk("rst.ready_held", 64'(req_ready), 64'(3'b000));
    rst_n = 1'b1;
    #1;
    chk("rst.first_grant", 64'(req_ready), 64'(3'b001));

    // Contention: grant order 0,1,2,0,1,2 with a write every cycle.
    for (int i = 0; i < 6; i++) begin
      chk("cont.ready", 64'(req_ready), 64'(3'b001 << (i % 3)));
      cyc();
      exp_wr("cont", d[i % 3], 16'h0002 << (i % 3), dt[i % 3]);
    end
    req_valid = 3'b000;
    #1;
    chk("idle.ready", 64'(req_ready), 64'(3'b000));
    cyc();
    exp_idle("idle", 4'd3, 32'h3333_0002);

    // Single request from the load unit.
    d[1] = 4'd9;
    dt[1] = 32'h0608_0020;
    req_valid = 3'b010;
    #1;
    chk("single.ready", 64'(req_ready), 64'(3'b010));
    cyc();
    req_valid = 3'b000;
    exp_wr("single", 4'd9, 16'h0200, 32'h0608_0020);
    chk("single.count7", 64'(wr_count), 64'(16'd7));

    // Fairness: requester 2 goes ahead of a re-grant to requester 0.
    req_valid = 3'b001;
    #1;
    chk("fair.ready0", 64'(req_ready), 64'(3'b001));
    cyc();
    exp_wr("fair.w0", 4'd1, 16'h0002, 32'h1111_0000);
    req_valid = 3'b101;
    #1;
    chk("fair.ready2", 64'(req_ready), 64'(3'b100));
    cyc();
    exp_wr("fair.w2", 4'd3, 16'h0008, 32'h3333_0002);
    req_valid = 3'b001;
    #1;
    chk("fair.ready0b", 64'(req_ready), 64'(3'b001));
    cyc();
    exp_wr("fair.w0b", 4'd1, 16'h0002, 32'h1111_0000);

    // Hold for 3 cycles; the write granted just before still landed above.
    hold = 1'b1;
    req_valid = 3'b101;
    #1;
    chk("hold.ready", 64'(req_ready), 64'(3'b000));
    for (int i = 0; i < 3; i++) begin
      cyc();
      exp_idle("hold", 4'd1, 32'h1111_0000);
      chk("hold.ready_in", 64'(req_ready), 64'(3'b000));
    end
    hold = 1'b0;
    #1;
    chk("hold.resume", 64'(req_ready), 64'(3'b100));
    cyc();
    req_valid = 3'b001;
    exp_wr("hold.w2", 4'd3, 16'h0008, 32'h3333_0002);
    #1;
    chk("hold.next", 64'(req_ready), 64'(3'b001));
    cyc();
    req_valid = 3'b000;
    exp_wr("hold.w0", 4'd1, 16'h0002, 32'h1111_0000);

    // Bring rr_ptr back to 0 with a lone grant to requester 2.
    req_valid = 3'b100;
    #1;
    chk("waw.pre_ready", 64'(req_ready), 64'(3'b100));
    cyc();
    req_valid = 3'b000;
    exp_wr("waw.pre", 4'd3, 16'h0008, 32'h3333_0002);

    // Same destination from requesters 0 and 1: 0 first, then 1.
    d[0] = 4'd0; d[1] = 4'd0;
    dt[0] = 32'h0628_0060; dt[1] = 32'hDEAD_BEEF;
    req_valid = 3'b011;
    #1;
    chk("waw.ready0", 64'(req_ready), 64'(3'b001));
    cyc();
    req_valid = 3'b010;
    exp_wr("waw.w0", 4'd0, 16'h0001, 32'h0628_0060);
    #1;
    chk("waw.ready1", 64'(req_ready), 64'(3'b010));
    cyc();
    req_valid = 3'b000;
    exp_wr("waw.w1", 4'd0, 16'h0001, 32'hDEAD_BEEF);
    chk("waw.count15", 64'(wr_count), 64'(16'd15));

    // Counter wrap: stream grants up to 16'hFFFF, then one more.
    n = int'(16'hFFFF - exp_cnt);
    req_valid = 3'b001;
    repeat (n) cyc();
    req_valid = 3'b000;
    exp_cnt = 16'hFFFF;
    chk("wrap.ffff", 64'(wr_count), 64'(16'hFFFF));
    cyc();
    exp_idle("wrap.idle", 4'd0, 32'h0628_0060);
    req_valid = 3'b001;
    #1;
    cyc();
    req_valid = 3'b000;
    exp_wr("wrap.w", 4'd0, 16'h0001, 32'h0628_0060);
    chk("wrap.zero", 64'(wr_count), 64'(16'h0000));

    // Reset mid-stream clears outputs at once; order restarts at requester 0.
    req_valid = 3'b111;
    #1;
    chk("mrst.ready1", 64'(req_ready), 64'(3'b010));
    cyc();
    rst_n = 1'b0;
    #1;
    exp_reset("mrst");
    exp_cnt = 16'h0000;
    rst_n = 1'b1;
    #1;
    chk("mrst.first_grant", 64'(req_ready), 64'(3'b001));
    cyc();
    req_valid = 3'b000;
    exp_wr("mrst.w0", 4'd0, 16'h0001, 32'h0628_0060);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regbank_wb_arbiter.md
# regbank_wb_arbiter

Write-port arbiter and sequencer for the 16 x 32-bit register bank. Three writeback sources (ALU, load unit, multiplier) compete for the bank's single write port; the block grants one per cycle using round-robin priority and drives the registered destination index, one-hot write enable and write data that feed the bank. It sits between the execute/memory stages and the register bank and replaces the direct destination/data drive into the 4-to-16 decoder.

## Interface
Parameters:
- NREQ, 3, number of writeback requesters; fixed at 3, index 0 = ALU, 1 = load, 2 = multiplier
- DW, 32, data width
- AW, 4, register index width (16 registers)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  3  per-requester write request
- req_dest  in  3*AW  per-requester destination index, requester k in bits [4k+3:4k]
- req_data  in  3*DW  per-requester write data, requester k in bits [32k+31:32k]
- req_ready  out  3  per-requester grant/accept (combinational)
- hold  in  1  freeze: no grants while high
- wr_en  out  1  registered write strobe to the register bank
- wr_dest  out  AW  registered destination index
- wr_onehot  out  16  decoded enable, bit wr_dest set only when wr_en=1
- wr_data  out  DW  registered write data
- wr_count  out  16  number of writes issued, wraps

## Operation
- Handshake: transfer for requester k when req_valid[k] && req_ready[k]. Requester holds valid, dest, data stable until accepted; it may not withdraw a raised valid.
- At most one req_ready bit high per cycle; req_ready[k] high only if req_valid[k]=1 and hold=0.
- Round-robin pointer rr_ptr in {0,1,2}: search order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3); first valid requester wins.
- After a grant to k: rr_ptr <= (k+1) mod 3. No grant: rr_ptr unchanged.
- hold=1: all req_ready=0, rr_ptr unchanged, next-cycle wr_en=0.
- Granted payload captured into wr_dest/wr_data; wr_en=1 for exactly one cycle per grant.
- wr_onehot = (1 << wr_dest) when wr_en=1, else 16'h0000; never more than one bit set.
- wr_dest/wr_data retain last granted value when wr_en=0 (don't-care to bank, but stable).
- wr_count increments by 1 on each cycle wr_en=1; 16'hFFFF wraps to 16'h0000.
- Same destination from two requesters: serialized by priority order; later grant's data is final bank content.
- Register 0 is writable like any other register; no special casing.

## Timing
- Reset (rst_n=0, asynchronous): wr_en=0, wr_dest=0, wr_data=0, wr_onehot=0, wr_count=0, rr_ptr=0. req_ready=0 while rst_n=0.
- Grant cycle N (combinational req_ready) -> wr_en/wr_dest/wr_data/wr_onehot valid in cycle N+1; latency 1 cycle.
- Throughput: one write per cycle with continuous requests.
- Reset asserted mid-stream: pending un-issued grant discarded, outputs clear immediately; after release first grant follows order 0,1,2.
- hold raised in cycle N: a grant made in N-1 still issues its write in N; nothing granted in N.
- Worst-case wait for a continuously valid requester: 2 grants to others (3 cycles with hold=0).

## Test plan
- Reset: drive rst_n=0 mid-cycle with all valid=1 -> all outputs 0 immediately, req_ready=3'b000; release -> first grant to requester 0.
- Single request: valid=3'b010, dest=4'd9, data=32'h0608_0020 -> req_ready=3'b010 in cycle N; cycle N+1 wr_en=1, wr_dest=9, wr_onehot=16'h0200, wr_data=32'h0608_0020, wr_count=1.
- Contention: valid=3'b111 held 6 cycles from reset -> grant order 0,1,2,0,1,2; wr_en high 6 consecutive cycles; wr_count=6.
- Fairness: requester 0 always valid, requester 2 raises valid after grant to 0 -> requester 2 granted next cycle ahead of re-grant to 0.
- Hold: valid=3'b101, hold=1 for 3 cycles -> req_ready=0, wr_en=0 during hold+1; on hold=0 grant follows unchanged rr_ptr.
- Same-dest WAW: req 0 dest=0 data=32'h0628_0060, req 1 dest=0 data=32'hDEAD_BEEF, both valid at rr_ptr=0 -> writes issue in order 0 then 1; wr_onehot=16'h0001 both cycles; wr_count wrap check from 16'hFFFF -> 16'h0000.
